// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/bubble scheduler for the 5-stage RV32 pipeline with AES extension.
// Sequences the multi-cycle AES round datapath and counts stalled cycles.
module pipe_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16,
  parameter int NR_128 = 10,
  parameter int NR_192 = 12,
  parameter int NR_256 = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_uses_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  input  logic              ex_branch_taken,
  input  logic              ex_jump,
  input  logic              ex_aes_en,
  input  logic [1:0]        ex_key_size,
  input  logic              ex_ecall,
  input  logic              resume,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              if_id_flush,
  output logic              id_ex_en,
  output logic              id_ex_flush,
  output logic              ex_mem_start,
  output logic              aes_start,
  output logic [3:0]        aes_round,
  output logic              aes_last,
  output logic              aes_busy,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_AES  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [3:0] NR_128_W = 4'(NR_128);
  localparam logic [3:0] NR_192_W = 4'(NR_192);
  localparam logic [3:0] NR_256_W = 4'(NR_256);

  state_t           state_r, state_nxt_s;
  logic [3:0]       rnd_cnt_r, rnd_cnt_nxt_s;
  logic [3:0]       nr_q_r, nr_q_nxt_s;
  logic [CNT_W-1:0] stall_cnt_r;

  logic       pc_en_s, if_id_en_s, if_id_flush_s, id_ex_en_s, id_ex_flush_s;
  logic       ex_mem_start_s, aes_start_s, aes_last_s, aes_busy_s, halted_s;
  logic [3:0] aes_round_s;
  logic       load_use_s;

  // Round count for a key size; the reserved code falls back to AES-128.
  function automatic logic [3:0] nr_sel(input logic [1:0] ks);
    logic [3:0] nr;
    case (ks)
      2'b01:   nr = NR_192_W;
      2'b10:   nr = NR_256_W;
      default: nr = NR_128_W;
    endcase
    return nr;
  endfunction

  assign load_use_s = ex_mem_read && (ex_rd != {REG_AW{1'b0}}) &&
                      ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

  // Next-state and pipeline control decode.
  always_comb begin
    state_nxt_s    = state_r;
    rnd_cnt_nxt_s  = rnd_cnt_r;
    nr_q_nxt_s     = nr_q_r;
    pc_en_s        = 1'b0;
    if_id_en_s     = 1'b0;
    if_id_flush_s  = 1'b0;
    id_ex_en_s     = 1'b0;
    id_ex_flush_s  = 1'b0;
    ex_mem_start_s = 1'b0;
    aes_start_s    = 1'b0;
    aes_round_s    = 4'd0;
    aes_last_s     = 1'b0;
    aes_busy_s     = 1'b0;
    halted_s       = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (ex_ecall) begin
          // Let the ecall retire while squashing everything younger.
          ex_mem_start_s = 1'b1;
          if_id_flush_s  = 1'b1;
          id_ex_flush_s  = 1'b1;
          id_ex_en_s     = 1'b1;
          state_nxt_s    = ST_HALT;
        end else if (ex_aes_en) begin
          aes_start_s   = 1'b1;
          nr_q_nxt_s    = nr_sel(ex_key_size);
          rnd_cnt_nxt_s = 4'd1;
          state_nxt_s   = ST_AES;
        end else if (ex_branch_taken || ex_jump) begin
          pc_en_s        = 1'b1;
          if_id_en_s     = 1'b1;
          if_id_flush_s  = 1'b1;
          id_ex_en_s     = 1'b1;
          id_ex_flush_s  = 1'b1;
          ex_mem_start_s = 1'b1;
        end else if (load_use_s) begin
          id_ex_en_s     = 1'b1;
          id_ex_flush_s  = 1'b1;
          ex_mem_start_s = 1'b1;
        end else begin
          pc_en_s        = 1'b1;
          if_id_en_s     = 1'b1;
          id_ex_en_s     = 1'b1;
          ex_mem_start_s = 1'b1;
        end
      end
      ST_AES: begin
        aes_busy_s  = 1'b1;
        aes_round_s = rnd_cnt_r;
        if (rnd_cnt_r == nr_q_r) begin
          aes_last_s     = 1'b1;
          pc_en_s        = 1'b1;
          if_id_en_s     = 1'b1;
          id_ex_en_s     = 1'b1;
          ex_mem_start_s = 1'b1;
          rnd_cnt_nxt_s  = 4'd0;
          state_nxt_s    = ST_RUN;
        end else begin
          rnd_cnt_nxt_s = rnd_cnt_r + 4'd1;
        end
      end
      ST_HALT: begin
        halted_s = 1'b1;
        if (resume) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_HALT;
        end
      end
      default: begin
        state_nxt_s   = ST_RUN;
        rnd_cnt_nxt_s = 4'd0;
      end
    endcase
  end

  // State, round counter and round limit registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_RUN;
      rnd_cnt_r <= 4'd0;
      nr_q_r    <= NR_128_W;
    end else begin
      state_r   <= state_nxt_s;
      rnd_cnt_r <= rnd_cnt_nxt_s;
      nr_q_r    <= nr_q_nxt_s;
    end
  end

  // Saturating count of cycles where the PC is held outside HALT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if ((state_r != ST_HALT) && !pc_en_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  // Every control output is held low while reset is asserted.
  assign pc_en        = reset & pc_en_s;
  assign if_id_en     = reset & if_id_en_s;
  assign if_id_flush  = reset & if_id_flush_s;
  assign id_ex_en     = reset & id_ex_en_s;
  assign id_ex_flush  = reset & id_ex_flush_s;
  assign ex_mem_start = reset & ex_mem_start_s;
  assign aes_start    = reset & aes_start_s;
  assign aes_round    = {4{reset}} & aes_round_s;
  assign aes_last     = reset & aes_last_s;
  assign aes_busy     = reset & aes_busy_s;
  assign halted       = reset & halted_s;
  assign stall_cnt    = stall_cnt_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed vectors push expected output
// words into a queue; a negedge monitor pops and compares them.
module tb_pipe_hazard_ctrl;

  logic       clk, reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs2, ex_mem_read, ex_branch_taken, ex_jump, ex_aes_en, ex_ecall, resume;
  logic [1:0] ex_key_size;
  logic       pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_start;
  logic       aes_start, aes_last, aes_busy, halted;
  logic [3:0] aes_round;
  logic [15:0] stall_cnt;

  // narrow-counter instance for saturation
  logic       sat_load;
  logic       s_pc, s_ife, s_iff, s_ide, s_idf, s_ems, s_ast, s_al, s_ab, s_h;
  logic [3:0] s_rnd, s_cnt;

  typedef struct {
    string       nm;
    logic [29:0] v;
    logic        sat;
  } item_t;

  item_t exp_q[$];
  int n_chk  = 0;
  int n_pass = 0;
  int n_push = 0;

  pipe_hazard_ctrl dut (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .ex_jump(ex_jump), .ex_aes_en(ex_aes_en), .ex_key_size(ex_key_size), .ex_ecall(ex_ecall),
    .resume(resume), .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .ex_mem_start(ex_mem_start),
    .aes_start(aes_start), .aes_round(aes_round), .aes_last(aes_last), .aes_busy(aes_busy),
    .halted(halted), .stall_cnt(stall_cnt)
  );

  pipe_hazard_ctrl #(.CNT_W(4)) sat_dut (
    .clk(clk), .reset(reset), .id_rs1(5'd1), .id_rs2(5'd0), .id_uses_rs2(1'b0),
    .ex_rd(5'd1), .ex_mem_read(sat_load), .ex_branch_taken(1'b0),
    .ex_jump(1'b0), .ex_aes_en(1'b0), .ex_key_size(2'b00), .ex_ecall(1'b0),
    .resume(1'b0), .pc_en(s_pc), .if_id_en(s_ife), .if_id_flush(s_iff),
    .id_ex_en(s_ide), .id_ex_flush(s_idf), .ex_mem_start(s_ems),
    .aes_start(s_ast), .aes_round(s_rnd), .aes_last(s_al), .aes_busy(s_ab),
    .halted(s_h), .stall_cnt(s_cnt)
  );

  always #5 clk = ~clk;

  // ctl = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_start, aes_start}
  // st  = {aes_last, aes_busy, halted}
  function automatic logic [29:0] ev(input logic [6:0] c, input logic [3:0] r,
                                     input logic [2:0] s, input logic [15:0] n);
    return {c, r, s, n};
  endfunction

  localparam logic [6:0] C_RUN  = 7'b1101010;
  localparam logic [6:0] C_LU   = 7'b0001110;
  localparam logic [6:0] C_BR   = 7'b1111110;
  localparam logic [6:0] C_ECL  = 7'b0011110;
  localparam logic [6:0] C_AST  = 7'b0000001;
  localparam logic [6:0] C_NONE = 7'b0000000;

  task automatic chk(input string nm, input logic [29:0] v);
    item_t it;
    it.nm = nm; it.v = v; it.sat = 1'b0;
    exp_q.push_back(it);
    n_push++;
    @(posedge clk); #1;
  endtask

  task automatic chk_sat(input string nm, input logic [3:0] cnt);
    item_t it;
    it.nm = nm; it.v = {26'd0, cnt}; it.sat = 1'b1;
    exp_q.push_back(it);
    n_push++;
    @(posedge clk); #1;
  endtask

  task automatic clr();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs2 = 1'b0; ex_rd = 5'd0;
    ex_mem_read = 1'b0; ex_branch_taken = 1'b0; ex_jump = 1'b0;
    ex_aes_en = 1'b0; ex_key_size = 2'b00; ex_ecall = 1'b0;
  endtask

  // Monitor: pops one expectation per cycle and compares.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      item_t it;
      logic [29:0] act;
      it = exp_q.pop_front();
      if (it.sat)
        act = {26'd0, s_cnt};
      else
        act = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_start, aes_start,
               aes_round, aes_last, aes_busy, halted, stall_cnt};
      n_chk++;
      if (act === it.v) n_pass++;
      else $display("FAIL %s: got %h expected %h", it.nm, act, it.v);
    end
  end

  // AES sequence from entry to completion; cnt0 is stall_cnt on entry.
  task automatic run_aes(input string nm, input logic [1:0] ks, input int nr, input int cnt0);
    ex_aes_en = 1'b1; ex_key_size = ks;
    chk({nm, "_start"}, ev(C_AST, 4'd0, 3'b000, 16'(cnt0)));
    clr();
    // EX-stage inputs must be ignored while rounds run
    ex_branch_taken = 1'b1; ex_ecall = 1'b1; ex_key_size = 2'b10;
    for (int r = 1; r < nr; r++)
      chk({nm, "_rnd"}, ev(C_NONE, 4'(r), 3'b010, 16'(cnt0 + r)));
    chk({nm, "_last"}, ev(C_RUN, 4'(nr), 3'b110, 16'(cnt0 + nr)));
    clr();
    chk({nm, "_done"}, ev(C_RUN, 4'd0, 3'b000, 16'(cnt0 + nr)));
  endtask

  initial begin
    clk = 1'b0; reset = 1'b0; resume = 1'b0; sat_load = 1'b0;
    clr();
    ex_mem_read = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; ex_branch_taken = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if ({pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_start, aes_start,
         aes_round, aes_last, aes_busy, halted, stall_cnt, s_cnt} === 34'd0)
      n_pass++;
    else
      $display("FAIL reset_direct: outputs not all zero while reset is low");
    chk("reset_hold", ev(C_NONE, 4'd0, 3'b000, 16'd0));
    clr();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) chk("run_idle", ev(C_RUN, 4'd0, 3'b000, 16'd0));

    // load-use via rs2
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1; id_rs1 = 5'd3;
    chk("lu_rs2", ev(C_LU, 4'd0, 3'b000, 16'd0));
    clr();
    chk("lu_after", ev(C_RUN, 4'd0, 3'b000, 16'd1));
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs2 = 1'b1;
    chk("lu_x0", ev(C_RUN, 4'd0, 3'b000, 16'd1));
    ex_rd = 5'd7; id_rs2 = 5'd7; id_uses_rs2 = 1'b0; id_rs1 = 5'd2;
    chk("lu_rs2_unused", ev(C_RUN, 4'd0, 3'b000, 16'd1));
    id_rs1 = 5'd7;
    chk("lu_rs1", ev(C_LU, 4'd0, 3'b000, 16'd1));
    clr();
    ex_rd = 5'd7; id_rs1 = 5'd7;
    chk("no_load", ev(C_RUN, 4'd0, 3'b000, 16'd2));
    clr();

    // branch / jump flushes
    ex_branch_taken = 1'b1;
    chk("branch", ev(C_BR, 4'd0, 3'b000, 16'd2));
    clr(); ex_jump = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd4; id_rs1 = 5'd4;
    chk("jump_over_lu", ev(C_BR, 4'd0, 3'b000, 16'd2));
    clr();

    run_aes("aes192", 2'b01, 12, 2);
    run_aes("aes_rsv", 2'b11, 10, 14);
    ex_branch_taken = 1'b1;
    run_aes("aes_br", 2'b00, 10, 24);
    run_aes("aes256", 2'b10, 14, 34);

    // ecall wins over AES
    ex_ecall = 1'b1; ex_aes_en = 1'b1; ex_key_size = 2'b01;
    chk("ecall", ev(C_ECL, 4'd0, 3'b000, 16'd48));
    clr();
    ex_mem_read = 1'b1; ex_rd = 5'd6; id_rs1 = 5'd6;
    for (int i = 0; i < 3; i++) chk("halt", ev(C_NONE, 4'd0, 3'b001, 16'd49));
    clr();
    resume = 1'b1;
    chk("halt_resume", ev(C_NONE, 4'd0, 3'b001, 16'd49));
    resume = 1'b0;
    chk("after_resume", ev(C_RUN, 4'd0, 3'b000, 16'd49));

    // reset in the middle of an AES op
    ex_aes_en = 1'b1; ex_key_size = 2'b00;
    chk("aesr_start", ev(C_AST, 4'd0, 3'b000, 16'd49));
    clr();
    for (int r = 1; r < 6; r++) chk("aesr_rnd", ev(C_NONE, 4'(r), 3'b010, 16'(49 + r)));
    reset = 1'b0;
    chk("aes_abort", ev(C_NONE, 4'd0, 3'b000, 16'd0));
    reset = 1'b1;
    chk("post_abort", ev(C_RUN, 4'd0, 3'b000, 16'd0));
    chk("post_abort2", ev(C_RUN, 4'd0, 3'b000, 16'd0));

    // saturation on the 4-bit counter
    sat_load = 1'b1;
    repeat (13) @(posedge clk);
    #1;
    chk_sat("sat_cnt13", 4'd13);
    repeat (5) @(posedge clk);
    #1;
    chk_sat("sat_hold", 4'd15);
    chk_sat("sat_hold2", 4'd15);
    sat_load = 1'b0;

    @(posedge clk); #1;
    if ((exp_q.size() != 0) || (n_chk != n_push + 1) || (n_pass != n_chk))
      $display("FAIL final: %0d pending, %0d/%0d checks passed, %0d queued",
               exp_q.size(), n_pass, n_chk, n_push);
    else
      $display("PASS all checks");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush/bubble scheduler for the 5-stage RV32 pipeline with the AES extension.
- Drives the enable/flush controls of the IF/ID and ID/EX registers, and the `start` input of the EX/MEM register (low inserts a bubble).
- Sequences the multi-cycle AES round datapath while the AES instruction is held in EX.
- Resolves load-use hazards, branch/jump flushes and ecall halt.

Parameters:
- REG_AW, 5, register-address width.
- CNT_W, 16, stall performance counter width.
- NR_128, 10, AES rounds for key_size 2'b00 (also used for the reserved code 2'b11).
- NR_192, 12, AES rounds for key_size 2'b01.
- NR_256, 14, AES rounds for key_size 2'b10.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low.
- id_rs1  in  REG_AW  rs1 of the instruction in ID.
- id_rs2  in  REG_AW  rs2 of the instruction in ID.
- id_uses_rs2  in  1  ID instruction reads rs2.
- ex_rd  in  REG_AW  destination register of the instruction in EX.
- ex_mem_read  in  1  EX instruction is a load.
- ex_branch_taken  in  1  EX branch resolved taken.
- ex_jump  in  1  EX is jal/jalr.
- ex_aes_en  in  1  EX instruction is an AES op.
- ex_key_size  in  2  AES key size of the EX instruction.
- ex_ecall  in  1  EX instruction is ecall.
- resume  in  1  leave HALT.
- pc_en  out  1  PC register load enable.
- if_id_en  out  1  IF/ID load enable.
- if_id_flush  out  1  IF/ID clear.
- id_ex_en  out  1  ID/EX load enable.
- id_ex_flush  out  1  ID/EX clear (bubble).
- ex_mem_start  out  1  EX/MEM `start`; 0 = bubble.
- aes_start  out  1  one-cycle AES datapath kick.
- aes_round  out  4  current AES round index.
- aes_last  out  1  final round this cycle.
- aes_busy  out  1  state==AES.
- halted  out  1  state==HALT.
- stall_cnt  out  CNT_W  saturating stall-cycle count.

Behaviour:

State machine and registered state
- States: RUN, AES, HALT.
- Registered: state, rnd_cnt[3:0], nr_q[3:0], stall_cnt.
- All other outputs are combinational from state and inputs.
- While reset is low:
  - state=RUN, rnd_cnt=0, nr_q=NR_128, stall_cnt=0.
  - All outputs forced to 0, including enables.
- Reset asserted mid-AES or in HALT aborts immediately to RUN.

RUN, priority highest first
1. ex_ecall:
   - ex_mem_start=1, pc_en=0, if_id_en=0, if_id_flush=1, id_ex_flush=1, id_ex_en=1.
   - Next state HALT.
2. ex_aes_en:
   - aes_start=1, aes_round=0.
   - pc_en=0, if_id_en=0, id_ex_en=0, ex_mem_start=0.
   - nr_q <= NR(ex_key_size); rnd_cnt <= 1.
   - Next state AES.
3. ex_branch_taken | ex_jump:
   - pc_en=1, if_id_en=1, if_id_flush=1, id_ex_flush=1, id_ex_en=1, ex_mem_start=1.
4. Load-use: ex_mem_read && ex_rd!=0 && (ex_rd==id_rs1 || (id_uses_rs2 && ex_rd==id_rs2)):
   - pc_en=0, if_id_en=0, id_ex_en=1, id_ex_flush=1, ex_mem_start=1.
5. Otherwise:
   - pc_en=if_id_en=id_ex_en=ex_mem_start=1, flushes 0.
- In RUN: aes_round=0, aes_last=0, aes_busy=0.

AES
- aes_busy=1, aes_round=rnd_cnt.
- Each cycle rnd_cnt <= rnd_cnt+1.
- While rnd_cnt<nr_q: pc_en=if_id_en=id_ex_en=ex_mem_start=0, flushes 0.
- When rnd_cnt==nr_q:
  - aes_last=1, pc_en=if_id_en=id_ex_en=ex_mem_start=1.
  - Next state RUN; rnd_cnt <= 0.
- ex_* inputs are ignored during AES; the key size is taken only from nr_q.
- Total EX occupancy is nr_q+1 cycles: 11 / 13 / 15.

HALT
- halted=1; all enables 0, ex_mem_start=0, flushes 0.
- resume=1: next state RUN. The resume cycle itself still outputs HALT values.

stall_cnt
- Increments by 1 each cycle that state!=HALT and pc_en==0.
- Saturates at all-ones; never wraps.

Test Plan:
1. Reset release with no hazards → pc_en=if_id_en=id_ex_en=ex_mem_start=1 every cycle; stall_cnt stays 0.
2. ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 for one cycle → exactly one cycle of pc_en=0, id_ex_flush=1, ex_mem_start=1; stall_cnt=1. With ex_rd=0 → no stall.
3. ex_aes_en=1, ex_key_size=2'b01 → aes_start pulse; aes_round 0..12 over 13 cycles; aes_last=1 only at round 12; ex_mem_start=0 for 12 cycles then 1; stall_cnt=12. Repeat with 2'b11 → 10 rounds.
4. ex_aes_en and ex_branch_taken in the same cycle → AES wins (aes_start=1, if_id_flush=0). ex_ecall together with ex_aes_en → HALT, no aes_start.
5. ex_ecall → one cycle with both flushes=1 and ex_mem_start=1; then halted=1 and all enables 0 until resume; RUN resumes on the cycle after resume.
6. Assert reset at aes_round=6 → immediately aes_busy=0 and all outputs 0. After release, RUN with aes_round=0 and stall_cnt=0. Force stall_cnt to saturate (CNT_W=4 build) → holds at 15.
